program_loader: RTL and testbench

Boot-time sequencer for the MIPS pipeline's instruction and data memories. It accepts a word stream over a valid/ready handshake, parses a header, and writes the payload words into instruction memory and then data memory at consecutive addresses from 0. It holds the core in stall (`core_hold`) throughout, and releases it only after a complete, valid image has been written. It replaces hand-poked instruction and data writes, and sits between the host/stream source and `main`'s memory write ports.

---
 rtl/program_loader_if.sv | 33 +++
 rtl/program_loader.sv | 215 +++++++++++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if: stream input and memory-write bus between the boot host,
// the program loader and the pipeline's instruction/data memory write ports.
// The master side is the host/stream source; the slave side is the loader.
interface program_loader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_word;
    logic              in_ready;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] instructionAddress;
    logic              imem_we;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dataAddress;
    logic              dmem_we;
    logic              core_hold;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_word,
        input  in_ready, instruction, instructionAddress, imem_we,
               data, dataAddress, dmem_we, core_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_word,
        output in_ready, instruction, instructionAddress, imem_we,
               data, dataAddress, dmem_we, core_hold, done, error
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: boot-time sequencer that parses a header word, then streams
// NI instruction words and ND data words into the two memories at addresses
// counting up from 0, keeping the core stalled until the whole image is in.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum word over all payload words; without it the XOR logic is absent.
// The interface instance must use the same ADDR_W/DATA_W as this module.
module program_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.slave bus
);
    // One extra bit so a count of DEPTH can be reached without wrapping.
    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_INSTR,
        S_DATA,
        S_DRAIN,
        S_RUN,
        S_ERROR
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    // Where the stream goes once the last payload word has been taken, and
    // whether the loader keeps accepting words there.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t TAIL_STATE = S_CHECK;
    localparam logic   TAIL_READY = 1'b1;
`else
    localparam state_t TAIL_STATE = S_DRAIN;
    localparam logic   TAIL_READY = 1'b0;
`endif

    state_t            state;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     ni;
    logic [CW-1:0]     nd;
    logic              in_ready_q;
    logic [DATA_W-1:0] instruction_q;
    logic [ADDR_W-1:0] iaddr_q;
    logic              imem_we_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] daddr_q;
    logic              dmem_we_q;
    logic              core_hold_q;
    logic              done_q;
    logic              error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    logic       accept;
    logic [7:0] hdr_magic;
    logic [7:0] hdr_ni;
    logic [7:0] hdr_nd;
    logic       hdr_bad;

    assign accept    = bus.in_valid && in_ready_q;
    assign hdr_magic = bus.in_word[31:24];
    assign hdr_ni    = bus.in_word[15:8];
    assign hdr_nd    = bus.in_word[7:0];
    assign hdr_bad   = (hdr_magic != 8'hA5) || (32'(hdr_ni) > DEPTH) || (32'(hdr_nd) > DEPTH);

    // Sequencer: state, counters and every registered output in one place.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            ni            <= '0;
            nd            <= '0;
            in_ready_q    <= 1'b0;
            instruction_q <= '0;
            iaddr_q       <= '0;
            imem_we_q     <= 1'b0;
            data_q        <= '0;
            daddr_q       <= '0;
            dmem_we_q     <= 1'b0;
            core_hold_q   <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_HEADER;
                        in_ready_q <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state      <= S_ERROR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            ni  <= CW'(hdr_ni);
                            nd  <= CW'(hdr_nd);
                            idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum <= '0;
`endif
                            if (hdr_ni != 8'd0) begin
                                state <= S_INSTR;
                            end else if (hdr_nd != 8'd0) begin
                                state <= S_DATA;
                            end else begin
                                state      <= TAIL_STATE;
                                in_ready_q <= TAIL_READY;
                            end
                        end
                    end
                end
                S_INSTR: begin
                    if (accept) begin
                        instruction_q <= bus.in_word;
                        iaddr_q       <= idx[ADDR_W-1:0];
                        imem_we_q     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.in_word;
`endif
                        if (idx + 1'b1 == ni) begin
                            idx <= '0;
                            if (nd != '0) begin
                                state <= S_DATA;
                            end else begin
                                state      <= TAIL_STATE;
                                in_ready_q <= TAIL_READY;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        data_q    <= bus.in_word;
                        daddr_q   <= idx[ADDR_W-1:0];
                        dmem_we_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.in_word;
`endif
                        if (idx + 1'b1 == nd) begin
                            idx        <= '0;
                            state      <= TAIL_STATE;
                            in_ready_q <= TAIL_READY;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_word == csum) begin
                            state <= S_DRAIN;
                        end else begin
                            state   <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                S_DRAIN: begin
                    state       <= S_RUN;
                    core_hold_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                S_RUN: begin
                    if (bus.start) begin
                        state       <= S_HEADER;
                        in_ready_q  <= 1'b1;
                        core_hold_q <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (bus.start) begin
                        state      <= S_HEADER;
                        in_ready_q <= 1'b1;
                        error_q    <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready           = in_ready_q;
    assign bus.instruction        = instruction_q;
    assign bus.instructionAddress = iaddr_q;
    assign bus.imem_we            = imem_we_q;
    assign bus.data               = data_q;
    assign bus.dataAddress        = daddr_q;
    assign bus.dmem_we            = dmem_we_q;
    assign bus.core_hold          = core_hold_q;
    assign bus.done               = done_q;
    assign bus.error              = error_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader. Every accepted
// payload word pushes its expected memory write; a negedge monitor pops and
// compares each strobe, and flags strobes that are unexpected or late.
module tb_program_loader;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;

    localparam int K_NONE  = 0;
    localparam int K_INSTR = 1;
    localparam int K_DATA  = 2;

    typedef struct {
        bit          isData;
        int          addr;
        logic [31:0] word;
        int          cyc;
    } wr_t;

    logic clk;
    logic reset;
    int   cyc;
    int   compared;
    int   mismatched;
    wr_t  sb[$];
    logic [31:0] payload[$];

    program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock and a cycle count used to time expected writes.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Hard stop in case a wait somewhere never finishes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation
    // in the exact cycle after its word was accepted.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checkOutput("missing_we", 32'(sb[0].addr), 32'hFFFF_FFFF);
            void'(sb.pop_front());
        end
        if (bus.imem_we || bus.dmem_we) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                checkOutput("spurious_we", {30'd0, bus.dmem_we, bus.imem_we}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (e.isData) begin
                    checkOutput("dmem_we", {31'd0, bus.dmem_we}, 32'd1);
                    checkOutput("imem_we_off", {31'd0, bus.imem_we}, 32'd0);
                    checkOutput("dmem_addr", 32'(bus.dataAddress), 32'(e.addr));
                    checkOutput("dmem_data", bus.data, e.word);
                end else begin
                    checkOutput("imem_we", {31'd0, bus.imem_we}, 32'd1);
                    checkOutput("dmem_we_off", {31'd0, bus.dmem_we}, 32'd0);
                    checkOutput("imem_addr", 32'(bus.instructionAddress), 32'(e.addr));
                    checkOutput("imem_data", bus.instruction, e.word);
                end
            end
        end
    end

    // Present one word starting at a negedge, wait (bounded) for in_ready and
    // return on the negedge after it was accepted; in_valid stays high.
    task automatic applyStimulus(input logic [31:0] w, input int kind, input int addr);
        int budget;
        budget       = 0;
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        while (!bus.in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end else if (kind != K_NONE) begin
            wr_t e;
            e.isData = (kind == K_DATA);
            e.addr   = addr;
            e.word   = w;
            e.cyc    = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Send header plus payload[] (and checksum when built with it); optional
    // idle gap before every word after the header; then check release timing.
    task automatic sendImage(input logic [31:0] hdr, input bit gaps, input bit badSum);
        int ni;
        logic [31:0] x;
        ni = int'(hdr[15:8]);
        x  = 32'd0;
        applyStimulus(hdr, K_NONE, 0);
        for (int i = 0; i < payload.size(); i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            x = x ^ payload[i];
            if (i < ni) applyStimulus(payload[i], K_INSTR, i);
            else        applyStimulus(payload[i], K_DATA, i - ni);
        end
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(badSum ? 32'd0 : x, K_NONE, 0);
`else
        if (badSum) $display("[TB] checksum corruption requested without checksum build");
`endif
        bus.in_valid = 1'b0;
        if (badSum) begin
            checkOutput("bad_sum_error", {31'd0, bus.error}, 32'd1);
            checkOutput("bad_sum_hold", {31'd0, bus.core_hold}, 32'd1);
            @(negedge clk);
            checkOutput("bad_sum_done", {31'd0, bus.done}, 32'd0);
        end else begin
            checkOutput("drain_done", {31'd0, bus.done}, 32'd0);
            checkOutput("drain_hold", {31'd0, bus.core_hold}, 32'd1);
            checkOutput("drain_ready", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
            checkOutput("run_done", {31'd0, bus.done}, 32'd1);
            checkOutput("run_hold", {31'd0, bus.core_hold}, 32'd0);
            checkOutput("run_error", {31'd0, bus.error}, 32'd0);
        end
    endtask

    task automatic exampleImage();
        payload.delete();
        payload.push_back(32'h8C01_0000);
        payload.push_back(32'h2042_0003);
        payload.push_back(32'h0000_000C);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        cyc          = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle: words offered while not ready must be ignored.
        bus.in_valid = 1'b1;
        bus.in_word  = 32'hA500_0101;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("idle_hold", {31'd0, bus.core_hold}, 32'd1);
        checkOutput("idle_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("idle_done", {31'd0, bus.done}, 32'd0);
        checkOutput("idle_error", {31'd0, bus.error}, 32'd0);
        checkOutput("idle_imem_we", {31'd0, bus.imem_we}, 32'd0);
        checkOutput("idle_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
        checkOutput("idle_iaddr", 32'(bus.instructionAddress), 32'd0);

        // Example image, back to back.
        pulseStart();
        checkOutput("header_ready", {31'd0, bus.in_ready}, 32'd1);
        exampleImage();
        sendImage(32'hA500_0201, 1'b0, 1'b0);

        // Reload from RUN reasserts hold next cycle; then a bad magic.
        pulseStart();
        checkOutput("reload_hold", {31'd0, bus.core_hold}, 32'd1);
        checkOutput("reload_done", {31'd0, bus.done}, 32'd0);
        applyStimulus(32'hA400_0101, K_NONE, 0);
        bus.in_valid = 1'b0;
        checkOutput("magic_error", {31'd0, bus.error}, 32'd1);
        checkOutput("magic_hold", {31'd0, bus.core_hold}, 32'd1);
        checkOutput("magic_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) @(negedge clk);

        // Count of DEPTH+1 is rejected.
        pulseStart();
        checkOutput("error_cleared", {31'd0, bus.error}, 32'd0);
        applyStimulus(32'hA500_8100, K_NONE, 0);
        bus.in_valid = 1'b0;
        checkOutput("ni_over_error", {31'd0, bus.error}, 32'd1);

        // Recovery with a valid image.
        pulseStart();
        exampleImage();
        sendImage(32'hA500_0201, 1'b0, 1'b0);

        // Full instruction memory with in_valid toggling.
        pulseStart();
        payload.delete();
        for (int i = 0; i < DEPTH; i++) payload.push_back($urandom);
        sendImage(32'hA500_8000, 1'b1, 1'b0);

        // Data-only image with reserved bits set.
        pulseStart();
        payload.delete();
        for (int i = 0; i < 4; i++) payload.push_back($urandom);
        sendImage(32'hA5FF_0004, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        pulseStart();
        exampleImage();
        sendImage(32'hA500_0201, 1'b0, 1'b1);
`endif

        // Reset after 3 of 5 instruction words.
        pulseStart();
        applyStimulus(32'hA500_0500, K_NONE, 0);
        for (int i = 0; i < 3; i++) applyStimulus(32'h1000_0000 + 32'(i), K_INSTR, i);
        bus.in_word = 32'h1000_0003;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        checkOutput("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("rst_hold", {31'd0, bus.core_hold}, 32'd1);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_iaddr", 32'(bus.instructionAddress), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("rst_still_idle", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
